branch_target_predictor: RTL and testbench

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined RV32 core. It replaces the fixed "predict not taken, PC+4" fetch policy. It sits beside the IF-stage PC register: fetch looks up the PC and receives a predicted next PC. The branch-resolution stage feeds back the actual outcome, and the block reports mispredict and redirect target plus saturating performance counters.

---
 rtl/bp_pkg.sv | 39 +++
 rtl/bp_table.sv | 69 ++++++
 rtl/branch_target_predictor.sv | 162 ++++++++++++++++
 tb/tb_branch_target_predictor.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the branch target predictor.
//   ctr_t     : 2-bit saturating direction counter (SNT/WNT/WT/ST)
//   ctr_next  : saturating counter step for one resolved outcome
//   bp_meta_t : per-entry control fields (valid, is_jump, ctr). The tag and
//               target widths depend on the predictor parameters, so those
//               fields are stored beside the struct in bp_table.
// ----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic valid;
        logic is_jump;
        ctr_t ctr;
    } bp_meta_t;

    // Taken moves toward ST, not taken toward SNT, saturating at both ends.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        case (ctr)
            SNT:     res = taken ? WNT : SNT;
            WNT:     res = taken ? WT  : SNT;
            WT:      res = taken ? ST  : WNT;
            ST:      res = taken ? ST  : WT;
            default: res = SNT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bp_table.sv
// ----------------------------------------------------------------------------
// bp_table
// Direct-mapped storage for the branch target buffer.
//   clk, rst            : clock, synchronous active-high clear of valid/ctr
//   fetch_idx           : lookup index from the fetch PC
//   fetch_meta/tag/target : combinational contents at fetch_idx
//   upd_idx             : index of the resolved instruction
//   upd_meta/tag/target : combinational contents at upd_idx (read side of the
//                         read-modify-write performed by the top level)
//   wr_en/idx/meta/tag/target : synchronous write port
// Reads return the pre-write contents during a write cycle (no bypass).
// ----------------------------------------------------------------------------
module bp_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = PC_W - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] fetch_idx,
    output bp_meta_t         fetch_meta,
    output logic [TAG_W-1:0] fetch_tag,
    output logic [PC_W-1:0]  fetch_target,
    input  logic [IDX_W-1:0] upd_idx,
    output bp_meta_t         upd_meta,
    output logic [TAG_W-1:0] upd_tag,
    output logic [PC_W-1:0]  upd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bp_meta_t         wr_meta,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_target
);

    bp_meta_t         meta_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];

    // Only the control fields need clearing: a cleared valid bit makes the
    // stale tag/target unobservable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i] <= '0;
            end
        end else if (wr_en) begin
            meta_q[wr_idx] <= wr_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

    assign fetch_meta   = meta_q[fetch_idx];
    assign fetch_tag    = tag_q[fetch_idx];
    assign fetch_target = target_q[fetch_idx];

    assign upd_meta     = meta_q[upd_idx];
    assign upd_tag      = tag_q[upd_idx];
    assign upd_target   = target_q[upd_idx];

endmodule

// File: rtl/branch_target_predictor.sv
// ----------------------------------------------------------------------------
// branch_target_predictor
// Direct-mapped BTB with 2-bit direction counters beside the IF-stage PC.
//   fetch_pc       : PC to look up (combinational)
//   pred_taken     : lookup hit and predicted taken
//   pred_next_pc   : stored target when predicted taken, else fetch_pc+4
//   upd_*          : resolved branch/jump feedback from the resolution stage,
//                    qualified by upd_valid, including the carried prediction
//   mispredict     : carried prediction disagrees with the actual outcome
//   redirect_pc    : correct next PC (always driven; qualify with mispredict)
//   branch_cnt     : saturating count of updates since reset
//   mispred_cnt    : saturating count of mispredicts since reset
// ----------------------------------------------------------------------------
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_next_pc,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_is_jump,
    input  logic             upd_pred_taken,
    input  logic [PC_W-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag_in;
    bp_meta_t         fetch_meta;
    logic [TAG_W-1:0] fetch_tag;
    logic [PC_W-1:0]  fetch_target;
    logic             fetch_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag_in;
    bp_meta_t         upd_meta;
    logic [TAG_W-1:0] upd_tag;
    logic [PC_W-1:0]  upd_old_target;
    logic             upd_hit;

    logic             wr_en;
    bp_meta_t         wr_meta;
    logic [TAG_W-1:0] wr_tag;
    logic [PC_W-1:0]  wr_target;

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    assign fetch_idx    = fetch_pc[IDX_W+1:2];
    assign fetch_tag_in = fetch_pc[PC_W-1:IDX_W+2];
    assign upd_idx      = upd_pc[IDX_W+1:2];
    assign upd_tag_in   = upd_pc[PC_W-1:IDX_W+2];

    bp_table #(
        .ENTRIES (ENTRIES),
        .PC_W    (PC_W),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .fetch_idx    (fetch_idx),
        .fetch_meta   (fetch_meta),
        .fetch_tag    (fetch_tag),
        .fetch_target (fetch_target),
        .upd_idx      (upd_idx),
        .upd_meta     (upd_meta),
        .upd_tag      (upd_tag),
        .upd_target   (upd_old_target),
        .wr_en        (wr_en),
        .wr_idx       (upd_idx),
        .wr_meta      (wr_meta),
        .wr_tag       (wr_tag),
        .wr_target    (wr_target)
    );

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    assign fetch_hit    = fetch_meta.valid && (fetch_tag == fetch_tag_in);
    assign pred_taken   = fetch_hit && (fetch_meta.is_jump || fetch_meta.ctr[1]);
    assign pred_next_pc = pred_taken ? fetch_target : (fetch_pc + PC_W'(4));

    // ------------------------------------------------------------------
    // Update: train a hitting entry, allocate on a taken miss, ignore a
    // not-taken miss. Reset has priority inside the table.
    // ------------------------------------------------------------------
    assign upd_hit = upd_meta.valid && (upd_tag == upd_tag_in);

    always_comb begin
        wr_en   = 1'b0;
        wr_meta = '0;
        wr_tag  = upd_tag_in;
        wr_target = upd_target;
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en           = 1'b1;
                wr_meta.valid   = 1'b1;
                wr_meta.is_jump = upd_is_jump;
                wr_meta.ctr     = ctr_next(upd_meta.ctr, upd_taken);
                // Not-taken outcomes carry no useful target; keep the old one.
                wr_target       = upd_taken ? upd_target : upd_old_target;
            end else if (upd_taken) begin
                wr_en           = 1'b1;
                wr_meta.valid   = 1'b1;
                wr_meta.is_jump = upd_is_jump;
                wr_meta.ctr     = WT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mispredict / redirect
    // ------------------------------------------------------------------
    assign mispredict  = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : (upd_pc + PC_W'(4));

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_target_predictor
// Directed vector table for the documented scenarios, hand-written sequences
// for reset-with-update and counter saturation (a CNT_W=4 instance shares the
// stimulus), then randomized traffic against an array-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units
// later, before the next edge.
// ----------------------------------------------------------------------------
module tb_branch_target_predictor;

    localparam int ENTRIES = 16;
    localparam int PC_W    = 32;
    localparam int IDX_W   = 4;

    logic            clk;
    logic            rst;
    logic [31:0]     fetch_pc;
    logic            upd_valid;
    logic [31:0]     upd_pc;
    logic            upd_taken;
    logic [31:0]     upd_target;
    logic            upd_is_jump;
    logic            upd_pred_taken;
    logic [31:0]     upd_pred_target;

    logic            pred_taken;
    logic [31:0]     pred_next_pc;
    logic            mispredict;
    logic [31:0]     redirect_pc;
    logic [15:0]     branch_cnt;
    logic [15:0]     mispred_cnt;

    logic            s_pred_taken;
    logic [31:0]     s_pred_next_pc;
    logic            s_mispredict;
    logic [31:0]     s_redirect_pc;
    logic [3:0]      s_branch_cnt;
    logic [3:0]      s_mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_is_jump(upd_is_jump),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_target_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W), .CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(s_pred_taken), .pred_next_pc(s_pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_is_jump(upd_is_jump),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
        .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid  [ENTRIES];
    logic [31:0] m_pc     [ENTRIES];  // full PC that owns the entry
    logic [31:0] m_target [ENTRIES];
    bit          m_jump   [ENTRIES];
    int          m_ctr    [ENTRIES];  // 0..3
    int          m_bc, m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return m_valid[i] && ((m_pc[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return m_hit(pc) && (m_jump[i] || m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_pred(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 0;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    function automatic bit m_mis();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && upd_target != upd_pred_target));
    endfunction

    task automatic m_update();
        int i;
        if (!upd_valid) return;
        i = idx_of(upd_pc);
        m_bc++;
        if (m_mis()) m_mc++;
        if (m_hit(upd_pc)) begin
            m_ctr[i]  = upd_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                  : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (upd_taken) m_target[i] = upd_target;
            m_jump[i] = upd_is_jump;
        end else if (upd_taken) begin
            m_valid[i]  = 1;
            m_pc[i]     = upd_pc;
            m_target[i] = upd_target;
            m_jump[i]   = upd_is_jump;
            m_ctr[i]    = 2;
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_upd();
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_is_jump     = 1'b0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_upd();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    // Clock edge: the model absorbs the update presented this cycle.
    task automatic tick();
        @(posedge clk);
        if (!rst) m_update();
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        uj;
        logic        upt;
        logic [31:0] uptgt;
        logic        ept;
        logic [31:0] enext;
        logic        emis;
        logic [31:0] ered;
        int          ebc;
        int          emc;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
        input logic ut, input logic [31:0] utgt, input logic uj,
        input logic upt, input logic [31:0] uptgt,
        input logic ept, input logic [31:0] enext, input logic emis,
        input logic [31:0] ered, input int ebc, input int emc);
        vec_t v;
        v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.uj = uj; v.upt = upt; v.uptgt = uptgt; v.ept = ept;
        v.enext = enext; v.emis = emis; v.ered = ered; v.ebc = ebc; v.emc = emc;
        return v;
    endfunction

    initial begin
        logic [31:0] lo_w;

        // fpc, uv, upc, ut, utgt, uj, upt, uptgt | pt, next, mis, redirect, bc, mc
        vecs[0]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   0, 32'h44,  0, 32'h4,   0, 0);
        vecs[1]  = mk(32'h40, 1, 32'h40, 1, 32'h80,  0, 0, 32'h44,  0, 32'h44,  1, 32'h80,  0, 0);
        vecs[2]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   1, 32'h80,  0, 32'h4,   1, 1);
        vecs[3]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 1, 32'h80,  1, 32'h80,  1, 32'h44,  1, 1);
        vecs[4]  = mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 0, 32'h44,  0, 32'h44,  0, 32'h44,  2, 2);
        vecs[5]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   0, 32'h44,  0, 32'h4,   3, 2);
        vecs[6]  = mk(32'h80, 1, 32'h80, 1, 32'h100, 0, 0, 32'h84,  0, 32'h84,  1, 32'h100, 3, 2);
        vecs[7]  = mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   0, 32'h44,  0, 32'h4,   4, 3);
        vecs[8]  = mk(32'h80, 0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 32'h4,   4, 3);
        vecs[9]  = mk(32'h20, 1, 32'h20, 1, 32'h200, 1, 0, 32'h24,  0, 32'h24,  1, 32'h200, 4, 3);
        vecs[10] = mk(32'h20, 0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   1, 32'h200, 0, 32'h4,   5, 4);
        vecs[11] = mk(32'h20, 1, 32'h20, 1, 32'h200, 1, 1, 32'h200, 1, 32'h200, 0, 32'h200, 5, 4);
        vecs[12] = mk(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0,
                      0, 32'h0, 0, 32'h0, 6, 4);

        fetch_pc = 32'h0;
        do_reset();

        // ---- directed table ----
        for (int k = 0; k < 13; k++) begin
            fetch_pc        = vecs[k].fpc;
            upd_valid       = vecs[k].uv;
            upd_pc          = vecs[k].upc;
            upd_taken       = vecs[k].ut;
            upd_target      = vecs[k].utgt;
            upd_is_jump     = vecs[k].uj;
            upd_pred_taken  = vecs[k].upt;
            upd_pred_target = vecs[k].uptgt;
            #2;
            check($sformatf("vec%0d pred_taken", k),   64'(pred_taken),   64'(vecs[k].ept));
            check($sformatf("vec%0d pred_next_pc", k), 64'(pred_next_pc), 64'(vecs[k].enext));
            check($sformatf("vec%0d mispredict", k),   64'(mispredict),   64'(vecs[k].emis));
            check($sformatf("vec%0d redirect_pc", k),  64'(redirect_pc),  64'(vecs[k].ered));
            check($sformatf("vec%0d branch_cnt", k),   64'(branch_cnt),   64'(vecs[k].ebc));
            check($sformatf("vec%0d mispred_cnt", k),  64'(mispred_cnt),  64'(vecs[k].emc));
            tick();
        end
        idle_upd();

        // ---- reset together with a taken update: update dropped ----
        rst        = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_target = 32'h80;
        fetch_pc   = 32'h40;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_upd();
        m_reset();
        #2;
        check("rst_upd pred_taken",   64'(pred_taken),   64'(0));
        check("rst_upd pred_next_pc", 64'(pred_next_pc), 64'h44);
        check("rst_upd branch_cnt",   64'(branch_cnt),   64'(0));
        check("rst_upd mispred_cnt",  64'(mispred_cnt),  64'(0));
        fetch_pc = 32'h80;
        #1;
        check("rst_upd lookup 0x80",  64'(pred_taken),   64'(0));

        // ---- 20 mispredicted updates: small counters saturate at 15 ----
        for (int k = 0; k < 20; k++) begin
            upd_valid       = 1'b1;
            upd_pc          = 32'h1000 + 32'(k * 4);
            upd_taken       = 1'b1;
            upd_target      = 32'h8000 + 32'(k * 16);
            upd_is_jump     = 1'b0;
            upd_pred_taken  = 1'b0;
            upd_pred_target = upd_pc + 32'd4;
            #1;
            tick();
        end
        idle_upd();
        #1;
        check("sat small branch_cnt",  64'(s_branch_cnt),  64'(15));
        check("sat small mispred_cnt", 64'(s_mispred_cnt), 64'(15));
        check("sat big branch_cnt",    64'(branch_cnt),    64'(20));
        check("sat big mispred_cnt",   64'(mispred_cnt),   64'(20));

        // ---- randomized traffic against the reference model ----
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [31:0] tag_part;
            tag_part = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2));
            lo_w     = 32'($urandom_range(0, 3));
            fetch_pc = (tag_part << (IDX_W + 2)) | (32'($urandom_range(0, 15)) << 2) | lo_w;

            tag_part    = 32'($urandom_range(0, 2));
            upd_valid   = ($urandom_range(0, 3) != 0);
            upd_pc      = (tag_part << (IDX_W + 2)) | (32'($urandom_range(0, 15)) << 2)
                          | 32'($urandom_range(0, 3));
            upd_is_jump = ($urandom_range(0, 4) == 0);
            upd_taken   = upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
            upd_target  = ($urandom_range(0, 1) == 1) ? 32'h2000 + 32'($urandom_range(0, 3) * 4)
                                                       : 32'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                upd_pred_taken  = m_pred(upd_pc);
                upd_pred_target = m_next(upd_pc);
            end else begin
                upd_pred_taken  = 1'($urandom_range(0, 1));
                upd_pred_target = ($urandom_range(0, 1) == 1) ? upd_target : upd_pc + 32'd4;
            end
            #2;
            check("rnd pred_taken",   64'(pred_taken),    64'(m_pred(fetch_pc)));
            check("rnd pred_next_pc", 64'(pred_next_pc),  64'(m_next(fetch_pc)));
            check("rnd mispredict",   64'(mispredict),    64'(m_mis()));
            check("rnd redirect_pc",  64'(redirect_pc),
                  64'(upd_taken ? upd_target : upd_pc + 32'd4));
            check("rnd branch_cnt",   64'(branch_cnt),    64'(sat(m_bc, 65535)));
            check("rnd mispred_cnt",  64'(mispred_cnt),   64'(sat(m_mc, 65535)));
            check("rnd small bcnt",   64'(s_branch_cnt),  64'(sat(m_bc, 15)));
            check("rnd small mcnt",   64'(s_mispred_cnt), 64'(sat(m_mc, 15)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the run is bounded even if an event never arrives.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
